// File: rtl/synth_pkg.sv
// Shared synth datapath definitions: wave codes, envelope limits and states,
// plus the phase-to-waveform mapping used by the sample-rate voices.
package synth_pkg;

  localparam int unsigned PHASE_W  = 24;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic [1:0] WAVE_SAW    = 2'd0;
  localparam logic [1:0] WAVE_SQUARE = 2'd1;
  localparam logic [1:0] WAVE_TRI    = 2'd2;
  localparam logic [1:0] WAVE_SILENT = 2'd3;

  localparam logic [15:0] ENV_MAX = 16'h7FFF;

  typedef enum logic [1:0] {
    ENV_IDLE    = 2'd0,
    ENV_ATTACK  = 2'd1,
    ENV_SUSTAIN = 2'd2,
    ENV_RELEASE = 2'd3
  } env_state_e;

  // ph is the top 16 bits of the phase accumulator.
  function automatic logic signed [SAMPLE_W-1:0] wave_lookup(input logic [1:0]  sel,
                                                             input logic [15:0] ph);
    logic [14:0] t;
    logic [15:0] w;
    t = ph[15] ? ~ph[14:0] : ph[14:0];
    case (sel)
      WAVE_SAW:    w = ph ^ 16'h8000;
      WAVE_SQUARE: w = ph[15] ? 16'h8001 : 16'h7FFF;
      WAVE_TRI:    w = {t, 1'b0} - 16'h8000;
      default:     w = 16'h0000;
    endcase
    return $signed(w);
  endfunction

endpackage

// File: rtl/tone_generator_if.sv
// Control/sample bus between the tone voice and its controller/DAC stage.
interface tone_generator_if;
  logic [synth_pkg::PHASE_W-1:0]         PHASE_INC;
  logic [1:0]                            WAVE_SEL;
  logic                                  GATE;
  logic signed [synth_pkg::SAMPLE_W-1:0] SAMPLE;
  logic                                  SAMPLE_VALID;

  modport master (output PHASE_INC, WAVE_SEL, GATE, input SAMPLE, SAMPLE_VALID);
  modport slave  (input PHASE_INC, WAVE_SEL, GATE, output SAMPLE, SAMPLE_VALID);
endinterface

// File: rtl/tone_generator_tick_sync.sv
// 2-FF synchronizer plus rising-edge detect; tick_c is one system-clock wide.
module tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic tick_c
);
  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign tick_c = sync_q & ~prev_q;
endmodule

// File: rtl/tone_generator.sv
// Enveloped tone voice: phase accumulator + linear attack/release envelope,
// advanced once per sample tick, with a three-stage output pipeline.
module tone_generator
  import synth_pkg::*;
#(
  parameter logic [15:0] ATTACK_STEP  = 16'd16,
  parameter logic [15:0] RELEASE_STEP = 16'd16
) (
  input  logic             CLK_50MHZ,
  input  logic             RESET_N,
  input  logic             CLK_44100HZ,
  tone_generator_if.slave  bus
);
  logic tick_c;

  env_state_e                    state_q, state_d;
  logic [15:0]                   env_q, env_d;
  logic [PHASE_W-1:0]            phase_q, phase_d;
  logic [1:0]                    wsel_q, wsel_d;
  logic                          v1_q, v1_d, v2_q, v2_d, valid_q, valid_d;
  logic signed [SAMPLE_W-1:0]    wave_q, wave_d, sample_q, sample_d;
  logic [16:0]                   att_sum;
  logic [15:0]                   att_env, rel_env;
  logic signed [16:0]            env_s;
  logic signed [32:0]            product;

  tick_sync u_tick_sync (
    .clk      (CLK_50MHZ),
    .rst_n    (RESET_N),
    .async_in (CLK_44100HZ),
    .tick_c   (tick_c)
  );

  assign att_sum = {1'b0, env_q} + {1'b0, ATTACK_STEP};
  assign att_env = (att_sum >= {1'b0, ENV_MAX}) ? ENV_MAX : att_sum[15:0];
  assign rel_env = (env_q > RELEASE_STEP) ? (env_q - RELEASE_STEP) : 16'd0;
  assign env_s   = $signed({1'b0, env_q});
  assign product = 33'(wave_q) * 33'(env_s);

  always_comb begin
    state_d  = state_q;
    env_d    = env_q;
    phase_d  = phase_q;
    wsel_d   = wsel_q;
    v1_d     = tick_c;
    v2_d     = v1_q;
    valid_d  = v2_q;
    wave_d   = wave_q;
    sample_d = sample_q;

    if (tick_c) begin
      wsel_d  = bus.WAVE_SEL;
      phase_d = phase_q + bus.PHASE_INC;
      case (state_q)
        ENV_IDLE: begin
          env_d = 16'd0;
          if (bus.GATE) begin
            state_d = ENV_ATTACK;
            phase_d = '0;
          end
        end
        ENV_ATTACK: begin
          if (!bus.GATE) begin
            state_d = ENV_RELEASE;
          end else begin
            env_d = att_env;
            if (att_env == ENV_MAX) state_d = ENV_SUSTAIN;
          end
        end
        ENV_SUSTAIN: begin
          env_d = ENV_MAX;
          if (!bus.GATE) state_d = ENV_RELEASE;
        end
        default: begin
          // Re-gating resumes attack from the current level without a phase reset.
          if (bus.GATE) begin
            env_d   = att_env;
            state_d = (att_env == ENV_MAX) ? ENV_SUSTAIN : ENV_ATTACK;
          end else begin
            env_d = rel_env;
            if (rel_env == 16'd0) state_d = ENV_IDLE;
          end
        end
      endcase
    end

    if (v1_q) wave_d = wave_lookup(wsel_q, phase_q[PHASE_W-1:PHASE_W-16]);
    if (v2_q) sample_d = 16'(product >>> 15);
  end

  always_ff @(posedge CLK_50MHZ or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= ENV_IDLE;
      env_q    <= 16'd0;
      phase_q  <= '0;
      wsel_q   <= WAVE_SAW;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      valid_q  <= 1'b0;
      wave_q   <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      env_q    <= env_d;
      phase_q  <= phase_d;
      wsel_q   <= wsel_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      valid_q  <= valid_d;
      wave_q   <= wave_d;
      sample_q <= sample_d;
    end
  end

  assign bus.SAMPLE       = sample_q;
  assign bus.SAMPLE_VALID = valid_q;
endmodule
